spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 46 ++++
 rtl/spi_sclk_div.sv | 37 +++
 rtl/spi_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register-write controller:
//   - frame width and field positions of the 16-bit {wr, addr, wdata} frame
//   - controller state encoding
//   - register address map of the attached peripheral
//   - pack_frame(): assembles a frame from its three fields
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int FRAME_W  = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Peripheral register map.
    localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic       wr,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        logic [FRAME_W-1:0] frame;
        frame                    = '0;
        frame[RW_BIT]            = wr;
        frame[ADDR_MSB:ADDR_LSB] = addr;
        frame[DATA_MSB:DATA_LSB] = data;
        return frame;
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// -----------------------------------------------------------------------------
// spi_sclk_div
// Half-period counter for the SPI serial clock. Counts clk cycles and emits a
// one-cycle tick on the DIV-th cycle after it was last cleared or ticked.
//
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   clear  in   restart the count (asserted on every controller state change)
//   tick   out  one-cycle pulse at the end of each DIV-cycle interval
// -----------------------------------------------------------------------------
module spi_sclk_div #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [7:0] cnt_q;

    assign tick = (cnt_q == 8'(DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// Sends one 16-bit SPI mode-0 frame {wr, addr[6:0], wdata[7:0]}, MSB first,
// per accepted start request. Frame sequence:
//   SETUP (cs low, sclk low, CLK_DIV cycles) -> SHIFT (16 sclk periods, each
//   CLK_DIV high + CLK_DIV low) -> HOLD (CLK_DIV) -> GAP (cs high, CLK_DIV)
//   -> one-cycle done pulse.
// A start accepted in cycle T yields done in cycle T + 1 + 35*CLK_DIV.
//
// Build option: define SPI_READBACK_EN to add the cipo input and rdata output.
// cipo is synchronised (2 flops) and sampled on sclk rising edges of bits 7..0;
// rdata is loaded in the done cycle of read frames (wr=0) and holds otherwise.
//
// Parameters
//   CLK_DIV  sclk half-period in clk cycles, 4..255 (default 8)
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   start  in   one-cycle frame request, accepted only when busy=0
//   wr     in   frame bit 15 (1=write, 0=read)
//   addr   in   frame bits 14:8
//   wdata  in   frame bits 7:0
//   busy   out  high from the cycle after acceptance through the done cycle
//   done   out  one-cycle pulse at frame completion
//   cs     out  active-low chip select
//   sclk   out  serial clock, idle low
//   copi   out  serial data out
//   cipo   in   serial data in            (SPI_READBACK_EN only)
//   rdata  out  last read payload         (SPI_READBACK_EN only)
// -----------------------------------------------------------------------------
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       cs,
    output logic       sclk,
    output logic       copi
`ifdef SPI_READBACK_EN
    ,
    input  logic       cipo,
    output logic [7:0] rdata
`endif
);

    generate
        if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("spi_controller: CLK_DIV must be in 4..255");
        end
    endgenerate

    spi_state_e         state_q;
    spi_state_e         state_nxt;
    logic [FRAME_W-1:0] sr_q;
    logic [FRAME_W-1:0] sr_nxt;
    logic [4:0]         bit_cnt_q;
    logic               last_q;
    logic               busy_q;
    logic               done_q;
    logic               cs_q;
    logic               sclk_q;
    logic               copi_q;

    logic               accept;
    logic               tick;
    logic               div_clear;
    logic               rise;
    logic               fall;
    logic               done_d;
    logic               frame_on_nxt;

    // A request in the done cycle sees busy=1 and is dropped.
    assign accept = start && !busy_q && (state_q == ST_IDLE);

    // The divider restarts on every state change so each state's dwell time
    // is measured from its first cycle; it is held at zero while idle.
    assign div_clear = (state_nxt != state_q) || (state_q == ST_IDLE);

    spi_sclk_div #(
        .DIV (CLK_DIV)
    ) u_sclk_div (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // last_q marks the 16th falling edge; the low half that follows it is the
    // final half-period of SHIFT. The bit counter itself stops at 15.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_nxt = state_q;
        rise      = 1'b0;
        fall      = 1'b0;
        done_d    = 1'b0;
        sr_nxt    = sr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_nxt = ST_SHIFT;
                    rise      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        fall = 1'b1;
                    end else if (last_q) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        rise = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_nxt = ST_IDLE;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (accept) begin
            sr_nxt = pack_frame(wr, addr, wdata);
        end else if (fall) begin
            sr_nxt = {sr_q[FRAME_W-2:0], 1'b0};
        end
    end

    assign frame_on_nxt = (state_nxt == ST_SETUP) ||
                          (state_nxt == ST_SHIFT) ||
                          (state_nxt == ST_HOLD);

    // Pin outputs are registered from next-state values so they change on the
    // same edge as the state and come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
        end else begin
            sr_q   <= sr_nxt;
            done_q <= done_d;
            cs_q   <= !frame_on_nxt;
            sclk_q <= (sclk_q || rise) && !fall;
            copi_q <= frame_on_nxt && sr_nxt[FRAME_W-1];

            if (accept) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end

            if (accept || done_d) begin
                bit_cnt_q <= '0;
                last_q    <= 1'b0;
            end else if (fall) begin
                if (bit_cnt_q == 5'd15) begin
                    last_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign cs   = cs_q;
    assign sclk = sclk_q;
    assign copi = copi_q;

`ifdef SPI_READBACK_EN
    logic [1:0] cipo_sync_q;
    logic [7:0] rx_q;
    logic       wr_q;

    // A rising edge issued while bit_cnt_q = k is rising edge k+1, so bits
    // 7..0 of the frame correspond to bit_cnt_q values 8..15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cipo_sync_q <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            rdata       <= '0;
        end else begin
            cipo_sync_q <= {cipo_sync_q[0], cipo};
            if (accept) begin
                wr_q <= wr;
            end
            if (rise && (bit_cnt_q >= 5'd8)) begin
                rx_q <= {rx_q[6:0], cipo_sync_q[1]};
            end
            if (done_d && !wr_q) begin
                rdata <= rx_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
// Self-checking bench for spi_controller (CLK_DIV = 8). Stimulus pushes the
// hand-computed frame, done cycle and read value of each request into a
// scoreboard queue; a monitor acting as the SPI peripheral decodes copi on
// sclk rising edges, drives cipo, and pops/compares whenever done pulses.
// Compile with +define+SPI_READBACK_EN to include the readback scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_controller;
    import spi_pkg::*;

    localparam int D   = 8;
    localparam int LAT = 281;   // 1 + 35*8 cycles from acceptance to done

    typedef struct {
        logic [15:0] frame;
        int          done_cyc;
        bit          chk_rd;
        logic [7:0]  rd;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       wr    = 1'b0;
    logic [6:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic       busy;
    logic       done;
    logic       cs;
    logic       sclk;
    logic       copi;
`ifdef SPI_READBACK_EN
    logic       cipo  = 1'b0;
    logic [7:0] rdata;
`endif

    spi_controller #(
        .CLK_DIV (D)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .cs    (cs),
        .sclk  (sclk),
        .copi  (copi)
`ifdef SPI_READBACK_EN
        ,
        .cipo  (cipo),
        .rdata (rdata)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    int          edge_cnt     = 0;
    int          cs_high_run  = 0;
    int          done_cnt     = 0;
    int          rise_cs_high = 0;
    int          unexp_done   = 0;
    int          issued       = 0;
    int          aborted      = 0;
    bit          seen_frame   = 0;
    logic        prev_sclk    = 1'b0;
    logic        prev_cs      = 1'b1;
    logic [15:0] rx_frame     = '0;
    logic [15:0] periph_resp  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Peripheral model + scoreboard consumer, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            edge_cnt    = 0;
            cs_high_run = 0;
            seen_frame  = 0;
            prev_sclk   = 1'b0;
            prev_cs     = 1'b1;
        end else begin
            if (sclk && !prev_sclk) begin
                if (cs) begin
                    rise_cs_high++;
                end else begin
                    rx_frame = {rx_frame[14:0], copi};
                    edge_cnt++;
                end
            end
`ifdef SPI_READBACK_EN
            if (!sclk && prev_sclk && !cs && edge_cnt < 16) begin
                cipo = periph_resp[15 - edge_cnt];
            end
`endif
            if (!cs && prev_cs) begin
                if (seen_frame) begin
                    check("cs_gap_ge_div", cs_high_run >= D, 1);
                end
                seen_frame = 1;
                edge_cnt   = 0;
                rx_frame   = '0;
`ifdef SPI_READBACK_EN
                cipo = periph_resp[15];
`endif
            end
            cs_high_run = cs ? cs_high_run + 1 : 0;

            if (done) begin
                if (sb_q.size() == 0) begin
                    unexp_done++;
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("frame_bits", rx_frame, e.frame);
                    check("sclk_edges", edge_cnt, 16);
                    check("done_cycle", cyc, e.done_cyc);
`ifdef SPI_READBACK_EN
                    if (e.chk_rd) check("rdata", rdata, e.rd);
`endif
                end
                done_cnt++;
            end
            prev_sclk = sclk;
            prev_cs   = cs;
        end
    end

    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic [15:0] exp_frame, input logic [15:0] resp,
                         input bit chk_rd, input logic [7:0] exp_rd);
        exp_t e;
        bit   idle_seen;
        idle_seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) begin
                idle_seen = 1;
                break;
            end
            @(negedge clk); #1;
        end
        check("idle_before_start", idle_seen, 1);
        periph_resp = resp;
        wr    = w;
        addr  = a;
        wdata = d;
        start = 1'b1;
        e.frame    = exp_frame;
        e.done_cyc = cyc + LAT;
        e.chk_rd   = chk_rd;
        e.rd       = exp_rd;
        sb_q.push_back(e);
        issued++;
        @(negedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done();
        int base;
        bit got;
        base = done_cnt;
        got  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (done_cnt != base) begin
                got = 1;
                break;
            end
        end
        check("done_within_budget", got, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_copi", copi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef SPI_READBACK_EN
        check("rst_rdata", rdata, 8'h00);
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Write 0x80 to pwm_duty: frame 1_0000100_10000000.
        issue(1'b1, REG_PWM_DUTY, 8'h80, 16'h8480, 16'h0000, 0, 8'h00);
        wait_done();

        // A start presented in the done cycle must be dropped.
        start = 1'b1; wr = 1'b0; addr = 7'h7F; wdata = 8'hFF;
        @(negedge clk); #1;
        start = 1'b0;
        check("start_in_done_ignored", busy, 0);

        // Back-to-back writes.
        issue(1'b1, REG_EN_OUT_7_0, 8'hA5, 16'h80A5, 16'h0000, 0, 8'h00);
        wait_done();
        issue(1'b1, REG_EN_OUT_15_8, 8'h3C, 16'h813C, 16'h0000, 0, 8'h00);
        wait_done();

        // Start mid-SHIFT with different fields: no effect, nothing queued.
        issue(1'b1, REG_EN_PWM_7_0, 8'h11, 16'h8211, 16'h0000, 0, 8'h00);
        repeat (100) @(negedge clk);
        #1;
        start = 1'b1; wr = 1'b0; addr = 7'h55; wdata = 8'hEE;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (320) @(negedge clk);
        #1;
        check("no_queued_frame", done_cnt, 4);

        // Reset after the 5th rising edge aborts the frame.
        issue(1'b1, REG_EN_PWM_15_8, 8'h55, 16'h8355, 16'h0000, 0, 8'h00);
        for (int i = 0; i < 200 && edge_cnt < 5; i++) begin
            @(negedge clk); #1;
        end
        check("edges_before_abort", edge_cnt, 5);
        rst = 1'b0;
        #1;
        check("abort_cs", cs, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        void'(sb_q.pop_front());
        aborted++;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        issue(1'b1, REG_EN_PWM_15_8, 8'h55, 16'h8355, 16'h0000, 0, 8'h00);
        wait_done();

`ifdef SPI_READBACK_EN
        // Read pwm enable low byte; peripheral answers 0x5A, then a write must
        // leave rdata untouched.
        issue(1'b0, REG_EN_PWM_7_0, 8'h00, 16'h0200, 16'h005A, 1, 8'h5A);
        wait_done();
        issue(1'b1, REG_PWM_DUTY, 8'h33, 16'h8433, 16'hFFFF, 1, 8'h5A);
        wait_done();
`endif

        repeat (20) @(negedge clk);
        #1;
        check("sclk_rise_while_cs_high", rise_cs_high, 0);
        check("unexpected_done", unexp_done, 0);
        check("frames_completed", done_cnt, issued - aborted);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
